alu_share_sched: RTL
====================

// Module: alu_share_sched
// PURPOSE
//  Shares the single ALU between two requesters, for example the execute stage and the branch/address unit.
//  - Arbitration is round-robin.
//  - Each request carries a 3-bit instruction class (kAorC/kSL/kSR/kSRO) and a 2-bit op_mne.
//  - kAorC ops complete in one execute cycle. Shifts run iteratively, one bit per cycle.
//  - One result at a time is returned over a valid/ready response channel tagged with the requester id.
// PARAMETERS
//  W    8  operand/result width
//  SHW  3  shift-amount width; shamt = b[SHW-1:0]
// PORTS
//  clk          in   1    clock, all state on rising edge
//  reset_n      in   1    synchronous reset, active-low
//  r0_valid     in   1    requester 0 has a request
//  r0_ready     out  1    requester 0 request accepted this cycle
//  r0_inst      in   3    instruction class (kAorC=000, kSL=011, kSR=100, kSRO=101)
//  r0_op        in   2    op_mne, used only for kAorC: ADDU, SUBU, AND, XOR
//  r0_a, r0_b   in   W    operands
//  r1_*         -    -    identical set for requester 1
//  rsp_valid    out  1    result available
//  rsp_ready    in   1    consumer takes result
//  rsp_id       out  1    requester that issued the result
//  rsp_result   out  W    result
//  rsp_carry    out  1    carry / borrow / shifted-out flag
//  rsp_err      out  1    undefined r*_inst
//  busy         out  1    state != IDLE
// BEHAVIOUR
//  Reset:
//  - On reset_n=0 at an edge: state=IDLE, last_grant=1, so requester 0 wins first.
//  - rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err all return to 0.
//  - r*_ready and busy go to 0 (combinational from IDLE).
//  - Reset mid-operation abandons the operation; no response is produced for it.
//  States: IDLE, EXEC, SHIFT, HOLD.
//  IDLE:
//  - grant = the only valid requester; if both are valid, the one != last_grant.
//  - r<grant>_ready=1 combinationally. The other ready stays 0, and both stay 0 in all other states.
//  - On valid&ready: latch inst/op/a/b/id, cnt=shamt, last_grant=id, then go to EXEC.
//  EXEC (1 cycle), operating on W bits:
//  - ADDU: {carry,result}=a+b.
//  - SUBU: result=a-b mod 2^W; carry=borrow (a<b, unsigned).
//  - AND / XOR: result computed, carry=0.
//  - Shift class with cnt!=0: acc=a, flag=0, go to SHIFT.
//  - Shift class with cnt==0: result=a, carry=0, go to HOLD.
//  - Undefined inst (001, 010, 110, 111): result=0, carry=0, err=1, go to HOLD.
//  SHIFT (one bit per cycle, cnt decrements; leave to HOLD when cnt reaches 0):
//  - kSL: acc<<=1, flag=bit shifted out.
//  - kSR: logical acc>>=1, flag=bit shifted out (last one wins).
//  - kSRO: logical acc>>=1, flag|=bit shifted out (sticky OR).
//  HOLD:
//  - rsp_valid=1; rsp_* stay stable until rsp_ready=1.
//  - Then go to IDLE with rsp_valid=0 next cycle.
//  - No new grant in the same cycle as the response handshake (one bubble).
//  Latency: request accepted at edge t. Kind of request -> rsp_valid first high:
//  - kAorC, shamt==0 or undefined inst -> cycle t+2.
//  - Shift with shamt n>0 -> cycle t+n+2.
//  Boundary rules:
//  - Requests arriving while busy wait; the requester holds valid, operands and inst stable.
//  - A requester that drops valid before ready is simply not granted.
//  - Back-to-back requests from one requester are taken while the other is idle.
//  - last_grant updates only on accept.
// TESTING
//  1. Reset, then r0 ADDU 0xF0+0x20 and r1 XOR 0xAA^0x0F in the same cycle, rsp_ready=1
//     -> id0 result 0x10 carry1 at t+2, then id1 result 0xA5 carry0.
//  2. SUBU a=0x05 b=0x07 -> result 0xFE carry1.
//     SUBU a=0x07 b=0x05 -> result 0x02 carry0.
//  3. kSL a=0x81 b=3 -> result 0x08 carry0, rsp_valid at t+5.
//     kSR a=0x09 b=2 -> result 0x02 carry0.
//     kSRO a=0x09 b=2 -> result 0x02 carry1.
//     Any shift with b=0 -> result=a at t+2.
//  4. Hold rsp_ready=0 for 5 cycles with both requesters valid
//     -> rsp stable, busy=1, r0_ready=r1_ready=0. Release -> one bubble, then the other id is granted.
//  5. reset_n=0 for 1 cycle during SHIFT (kSL b=7)
//     -> next cycle IDLE, rsp_valid=0, no stale response ever appears.
//  6. r0_inst=3'b111 -> rsp_err=1 result 0x00 carry0.
//     A following valid ADDU -> rsp_err=0.

Source files
------------

// File: rtl/alu_share_sched.sv
// Round-robin share of one ALU between two requesters.
// kAorC ops take one execute cycle; shifts iterate one bit per cycle.
module alu_share_sched #(
    parameter int W   = 8,
    parameter int SHW = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [2:0]   r0_inst,
    input  logic [1:0]   r0_op,
    input  logic [W-1:0] r0_a,
    input  logic [W-1:0] r0_b,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [2:0]   r1_inst,
    input  logic [1:0]   r1_op,
    input  logic [W-1:0] r1_a,
    input  logic [W-1:0] r1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_carry,
    output logic         rsp_err,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, HOLD} state_t;

    localparam logic [2:0] kAorC = 3'b000;
    localparam logic [2:0] kSL   = 3'b011;
    localparam logic [2:0] kSR   = 3'b100;
    localparam logic [2:0] kSRO  = 3'b101;

    state_t           stateQ, stateD;
    logic             lastGrant;
    logic             grant;
    logic             accept;
    logic [2:0]       selInst;
    logic [1:0]       selOp;
    logic [W-1:0]     selA, selB;
    logic [2:0]       instQ;
    logic [1:0]       opQ;
    logic [W-1:0]     aQ, bQ;
    logic [SHW-1:0]   cnt;
    logic [W-1:0]     acc;
    logic             flag;
    logic             errQ;
    logic             idQ;
    logic             isShift;
    logic [W:0]       sum;

    always_comb begin
        grant = (r0_valid && r1_valid) ? ~lastGrant : r1_valid;
        r0_ready = (stateQ == IDLE) && r0_valid && !grant;
        r1_ready = (stateQ == IDLE) && r1_valid && grant;
        accept = r0_ready || r1_ready;
        selInst = grant ? r1_inst : r0_inst;
        selOp = grant ? r1_op : r0_op;
        selA = grant ? r1_a : r0_a;
        selB = grant ? r1_b : r0_b;
        isShift = (instQ == kSL) || (instQ == kSR) || (instQ == kSRO);
        sum = {1'b0, aQ} + {1'b0, bQ};
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE:    if (accept) stateD = EXEC;
            EXEC:    stateD = (isShift && cnt != '0) ? SHIFT : HOLD;
            SHIFT:   if (cnt == SHW'(1)) stateD = HOLD;
            HOLD:    if (rsp_ready) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) stateQ <= IDLE;
        else stateQ <= stateD;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lastGrant <= 1'b1;
            idQ <= 1'b0;
            instQ <= '0;
            opQ <= '0;
            aQ <= '0;
            bQ <= '0;
            cnt <= '0;
            acc <= '0;
            flag <= 1'b0;
            errQ <= 1'b0;
        end else begin
            if (accept) begin
                instQ <= selInst;
                opQ <= selOp;
                aQ <= selA;
                bQ <= selB;
                cnt <= selB[SHW-1:0];
                idQ <= grant;
                lastGrant <= grant;
            end
            case (stateQ)
                EXEC: begin
                    errQ <= 1'b0;
                    flag <= 1'b0;
                    case (instQ)
                        kAorC: begin
                            case (opQ)
                                2'd0: {flag, acc} <= sum;
                                2'd1: begin
                                    acc <= aQ - bQ;
                                    flag <= aQ < bQ;
                                end
                                2'd2: acc <= aQ & bQ;
                                default: acc <= aQ ^ bQ;
                            endcase
                        end
                        kSL, kSR, kSRO: acc <= aQ;
                        default: begin
                            acc <= '0;
                            errQ <= 1'b1;
                        end
                    endcase
                end
                SHIFT: begin
                    cnt <= cnt - 1'b1;
                    case (instQ)
                        kSL: begin
                            acc <= {acc[W-2:0], 1'b0};
                            flag <= acc[W-1];
                        end
                        kSR: begin
                            acc <= {1'b0, acc[W-1:1]};
                            flag <= acc[0];
                        end
                        kSRO: begin
                            acc <= {1'b0, acc[W-1:1]};
                            flag <= flag | acc[0];
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (stateQ == HOLD);
    assign rsp_id = idQ;
    assign rsp_result = acc;
    assign rsp_carry = flag;
    assign rsp_err = errQ;
    assign busy = (stateQ != IDLE);

endmodule
